// File: rtl/mux_display_rx_pkg.sv
// mux_display_rx_pkg
// Constants shared between the display-bus receiver and the BCD-to-seven-
// segment encoder on the driving side: the segment pattern of each decimal
// digit, the active-low COM encoding of every scan slot, and the code that
// marks an undecodable digit. Also holds the receiver slot-FSM state type.
package mux_display_rx_pkg;

    // Segment lines are ordered {a,b,c,d,e,f,g}, active-high.
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

    // Digit commons, active-low one-hot; all-high is the blank slot.
    localparam logic [2:0] COM_A     = 3'b011;
    localparam logic [2:0] COM_B     = 3'b101;
    localparam logic [2:0] COM_C     = 3'b110;
    localparam logic [2:0] COM_BLANK = 3'b111;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCEPT = 2'd2
    } slot_state_t;

    // Forward mapping used by the encoder; values above 9 blank the digit.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/mux_display_rx_if.sv
// mux_display_rx_if
// Display bus as seen by the receiver.
//   seg[6:0]          segment lines {a..g}, driven by the scanner
//   com[2:0]          active-low digit commons, driven by the scanner
//   dig_a/b/c[3:0]    last published BCD digits, driven by the receiver
//   frame_valid       one-cycle publish strobe
//   err               frame error, meaningful while frame_valid is high
//   lost              no frame published for the timeout window
// master: scanner / bench side; slave: receiver side.
interface mux_display_rx_if;

    logic [6:0] seg;
    logic [2:0] com;
    logic [3:0] dig_a;
    logic [3:0] dig_b;
    logic [3:0] dig_c;
    logic       frame_valid;
    logic       err;
    logic       lost;

    modport master (
        output seg,
        output com,
        input  dig_a,
        input  dig_b,
        input  dig_c,
        input  frame_valid,
        input  err,
        input  lost
    );

    modport slave (
        input  seg,
        input  com,
        output dig_a,
        output dig_b,
        output dig_c,
        output frame_valid,
        output err,
        output lost
    );

endinterface

// File: rtl/seg7_bcd_decode.sv
// seg7_bcd_decode
// Combinational seven-segment pattern to BCD decoder.
//   seg[6:0]  segment pattern {a..g}
//   valid     pattern is one of the ten decimal digits
//   bcd[3:0]  decoded digit, or the invalid code when valid is low
module seg7_bcd_decode
    import mux_display_rx_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] bcd
);

    always_comb begin
        valid = 1'b1;
        bcd   = BCD_INVALID;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_display_rx.sv
// mux_display_rx
// Receiver for the three-digit multiplexed seven-segment display bus.
// Synchronizes SEG/COM, debounces each scan slot, decodes accepted digit
// slots into per-digit shadow registers and publishes an A/B/C frame when a
// blank slot is accepted after all three digits were captured.
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   slave side of mux_display_rx_if (seg/com in, digits/strobes out)
// Parameters:
//   STABLE_CYC  stability count needed before a slot is accepted (2..15)
//   TIMEOUT     cycles without a published frame before lost asserts
module mux_display_rx
    import mux_display_rx_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 65535
) (
    input logic             clk,
    input logic             rst,
    mux_display_rx_if.slave bus
);

    localparam logic [3:0]  ACCEPT_CNT  = 4'(STABLE_CYC - 1);
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic [2:0]  com_meta;
    logic [2:0]  com_sync;
    logic [6:0]  seg_meta;
    logic [6:0]  seg_sync;
    logic [9:0]  sample_prev;
    logic        change;
    logic [3:0]  stable_cnt;

    slot_state_t state;
    slot_state_t state_next;
    logic        accept;
    logic        publish;

    logic        dec_valid;
    logic [3:0]  dec_bcd;
    logic [3:0]  shadow_a;
    logic [3:0]  shadow_b;
    logic [3:0]  shadow_c;
    logic [2:0]  mask;
    logic        err_sticky;

    logic [15:0] idle_cnt;
    logic [15:0] idle_cnt_next;

    // Two-flop synchronizers; nothing downstream sees the raw pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com_meta <= '0;
            com_sync <= '0;
            seg_meta <= '0;
            seg_sync <= '0;
        end else begin
            com_meta <= bus.com;
            com_sync <= com_meta;
            seg_meta <= bus.seg;
            seg_sync <= seg_meta;
        end
    end

    assign change = ({com_sync, seg_sync} != sample_prev);

    // Stability counter: restarts on any change of the synchronized slot
    // and saturates so a long visit never wraps back into the accept value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_prev <= '0;
            stable_cnt  <= '0;
        end else begin
            sample_prev <= {com_sync, seg_sync};
            if (change) begin
                stable_cnt <= '0;
            end else if (stable_cnt != 4'hF) begin
                stable_cnt <= stable_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (change) state_next = ST_SETTLE;
            ST_SETTLE: if (accept) state_next = ST_ACCEPT;
            ST_ACCEPT: if (change) state_next = ST_SETTLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Only SETTLE can accept, so a slot is taken once per uninterrupted visit.
    always_comb begin
        accept  = (state == ST_SETTLE) && !change && (stable_cnt == ACCEPT_CNT);
        publish = accept && (com_sync == COM_BLANK) && (mask == 3'b111);
    end

    seg7_bcd_decode u_decode (
        .seg   (seg_sync),
        .valid (dec_valid),
        .bcd   (dec_bcd)
    );

    // Shadow capture. The decoder already yields the invalid code for
    // unknown patterns, so the shadow is written unconditionally and the
    // digit still counts as captured; only the sticky error records it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_a   <= '0;
            shadow_b   <= '0;
            shadow_c   <= '0;
            mask       <= '0;
            err_sticky <= 1'b0;
        end else if (accept) begin
            case (com_sync)
                COM_A: begin
                    shadow_a <= dec_bcd;
                    mask[0]  <= 1'b1;
                    if (!dec_valid) err_sticky <= 1'b1;
                end
                COM_B: begin
                    shadow_b <= dec_bcd;
                    mask[1]  <= 1'b1;
                    if (!dec_valid) err_sticky <= 1'b1;
                end
                COM_C: begin
                    shadow_c <= dec_bcd;
                    mask[2]  <= 1'b1;
                    if (!dec_valid) err_sticky <= 1'b1;
                end
                COM_BLANK: begin
                    mask       <= '0;
                    err_sticky <= 1'b0;
                end
                default: err_sticky <= 1'b1;
            endcase
        end
    end

    // Published outputs; digits and err hold between frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dig_a       <= '0;
            bus.dig_b       <= '0;
            bus.dig_c       <= '0;
            bus.frame_valid <= 1'b0;
            bus.err         <= 1'b0;
        end else begin
            bus.frame_valid <= publish;
            if (publish) begin
                bus.dig_a <= shadow_a;
                bus.dig_b <= shadow_b;
                bus.dig_c <= shadow_c;
                bus.err   <= err_sticky;
            end
        end
    end

    // Timeout counter is cleared by the same edge that raises frame_valid,
    // which lets lost drop in the publish cycle itself.
    always_comb begin
        if (publish) begin
            idle_cnt_next = '0;
        end else if (idle_cnt == TIMEOUT_CNT) begin
            idle_cnt_next = idle_cnt;
        end else begin
            idle_cnt_next = idle_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            bus.lost <= 1'b0;
        end else begin
            idle_cnt <= idle_cnt_next;
            bus.lost <= (idle_cnt_next == TIMEOUT_CNT);
        end
    end

endmodule

// File: tb/tb_mux_display_rx.sv
// tb_mux_display_rx
// Drives scan slots onto the display bus and compares every published frame
// against a slot-level model of the receiver's capture rules.
module tb_mux_display_rx;

    localparam int S = 4;
    localparam int T = 100;

    localparam logic [6:0] SEG_TAB [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                            7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    localparam logic [2:0] COMS [3] = '{3'b011, 3'b101, 3'b110};
    localparam logic [2:0] ILL  [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
    localparam logic [2:0] BLANK = 3'b111;

    typedef struct packed {
        int         cyc;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic       err;
        logic       lost;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mux_display_rx_if bus ();

    mux_display_rx #(.STABLE_CYC(S), .TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic lost_d = 1'b0;

    ev_t  obs_q [$];
    logic lb_q  [$];
    ev_t  exp_q [$];

    logic [3:0] m_sh  [3];
    logic [3:0] m_dig [3];
    logic [2:0] m_mask;
    logic       m_err;

    // Record every publish with the cycle it was seen and the lost level of
    // the cycle before.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.frame_valid === 1'b1) begin
            obs_q.push_back('{cyc, bus.dig_a, bus.dig_b, bus.dig_c, bus.err, bus.lost});
            lb_q.push_back(lost_d);
        end
        lost_d = bus.lost;
    end

    function automatic logic [3:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (SEG_TAB[i] == p) return 4'(i);
        end
        return 4'hF;
    endfunction

    task automatic model_clear();
        m_mask = 3'b000;
        m_err  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_sh[i]  = 4'd0;
            m_dig[i] = 4'd0;
        end
    endtask

    // Hold one slot on the pins for len cycles. Slots held S+2 or longer are
    // applied to the model; glitches of at most S-2 cycles are ignored by it.
    task automatic drive_slot(input logic [2:0] com, input logic [6:0] seg, input int len);
        int start;
        int idx;
        bus.com = com;
        bus.seg = seg;
        start   = cyc;
        if (len >= S + 2) begin
            idx = -1;
            for (int i = 0; i < 3; i++) if (COMS[i] == com) idx = i;
            if (idx >= 0) begin
                m_sh[idx]   = ref_decode(seg);
                m_mask[idx] = 1'b1;
                if (m_sh[idx] == 4'hF) m_err = 1'b1;
            end else if (com == BLANK) begin
                if (m_mask == 3'b111) begin
                    exp_q.push_back('{start + 3 + S, m_sh[0], m_sh[1], m_sh[2], m_err, 1'b0});
                    m_dig = m_sh;
                end
                m_mask = 3'b000;
                m_err  = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
        repeat (len) @(negedge clk);
    endtask

    task automatic drive_frame(input int a, input int b, input int c, input int len);
        drive_slot(COMS[0], SEG_TAB[a], len);
        drive_slot(COMS[1], SEG_TAB[b], len);
        drive_slot(COMS[2], SEG_TAB[c], len);
        drive_slot(BLANK, 7'h00, len);
    endtask

    task automatic start_test();
        obs_q.delete();
        lb_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.com = BLANK;
        bus.seg = 7'h00;
        rst     = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        n_vec++; if (bus.dig_a !== 4'd0) begin n_err++; $display("FAIL reset_dig_a: got %h, expected 0", bus.dig_a); end
        n_vec++; if (bus.dig_b !== 4'd0) begin n_err++; $display("FAIL reset_dig_b: got %h, expected 0", bus.dig_b); end
        n_vec++; if (bus.dig_c !== 4'd0) begin n_err++; $display("FAIL reset_dig_c: got %h, expected 0", bus.dig_c); end
        n_vec++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL reset_frame_valid: got %b, expected 0", bus.frame_valid); end
        n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b, expected 0", bus.err); end
        n_vec++; if (bus.lost !== 1'b0) begin n_err++; $display("FAIL reset_lost: got %b, expected 0", bus.lost); end
        rst = 1'b0;
        start_test();
        repeat (8) @(negedge clk);
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL reset_idle_frames: got %0d, expected 0", obs_q.size()); end
        n_vec++; if (bus.lost !== 1'b0) begin n_err++; $display("FAIL reset_idle_lost: got %b, expected 0", bus.lost); end
    endtask

    task automatic test_basic_frame();
        start_test();
        drive_frame(3, 7, 9, 8);
        repeat (S + 4) @(negedge clk);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL basic_frame%0d: got %p, expected %p", i, obs_q[i], exp_q[i]); end
        end
        n_vec++; if ({bus.dig_a, bus.dig_b, bus.dig_c, bus.err} !== {4'd3, 4'd7, 4'd9, 1'b0}) begin
            n_err++; $display("FAIL basic_digits: got %h/%h/%h err=%b, expected 3/7/9 err=0", bus.dig_a, bus.dig_b, bus.dig_c, bus.err);
        end
    endtask

    task automatic test_glitch();
        start_test();
        drive_slot(COMS[0], 7'h79, 8);
        drive_slot(COMS[1], 7'h70, 6);
        drive_slot(COMS[1], 7'h7F, 2);
        drive_slot(COMS[1], 7'h70, 6);
        drive_slot(COMS[2], 7'h7B, 8);
        drive_slot(BLANK, 7'h00, 8);
        repeat (S + 4) @(negedge clk);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL glitch_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL glitch_frame%0d: got %p, expected %p", i, obs_q[i], exp_q[i]); end
        end
        n_vec++; if ({bus.dig_a, bus.dig_b, bus.dig_c} !== {4'd3, 4'd7, 4'd9}) begin
            n_err++; $display("FAIL glitch_digits: got %h/%h/%h, expected 3/7/9", bus.dig_a, bus.dig_b, bus.dig_c);
        end
    endtask

    task automatic test_invalid_pattern();
        start_test();
        drive_slot(COMS[0], 7'h79, 8);
        drive_slot(COMS[1], 7'h70, 8);
        drive_slot(COMS[2], 7'h01, 8);
        drive_slot(BLANK, 7'h00, 8);
        drive_frame(1, 2, 4, 8);
        repeat (S + 4) @(negedge clk);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL invalid_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL invalid_frame%0d: got %p, expected %p", i, obs_q[i], exp_q[i]); end
        end
        if (obs_q.size() == 2) begin
            n_vec++; if ({obs_q[0].c, obs_q[0].err} !== {4'hF, 1'b1}) begin
                n_err++; $display("FAIL invalid_digit_c: got c=%h err=%b, expected c=f err=1", obs_q[0].c, obs_q[0].err);
            end
            n_vec++; if (obs_q[1].err !== 1'b0) begin n_err++; $display("FAIL invalid_next_err: got %b, expected 0", obs_q[1].err); end
        end
    endtask

    task automatic test_missing_digit();
        start_test();
        drive_slot(COMS[0], SEG_TAB[1], 8);
        drive_slot(COMS[1], SEG_TAB[2], 8);
        drive_slot(BLANK, 7'h00, 8);
        repeat (S + 4) @(negedge clk);
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL missing_no_frame: got %0d frames, expected 0", obs_q.size()); end
        n_vec++; if ({bus.dig_a, bus.dig_b, bus.dig_c} !== {m_dig[0], m_dig[1], m_dig[2]}) begin
            n_err++; $display("FAIL missing_hold: got %h/%h/%h, expected %h/%h/%h", bus.dig_a, bus.dig_b, bus.dig_c, m_dig[0], m_dig[1], m_dig[2]);
        end
        start_test();
        drive_frame(4, 5, 6, 8);
        repeat (S + 4) @(negedge clk);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL missing_next_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL missing_next_frame%0d: got %p, expected %p", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_illegal_com();
        start_test();
        drive_slot(COMS[0], SEG_TAB[5], 8);
        drive_slot(3'b001, 7'h30, 8);
        drive_slot(COMS[1], SEG_TAB[6], 8);
        drive_slot(COMS[2], SEG_TAB[0], 8);
        drive_slot(BLANK, 7'h00, 8);
        repeat (S + 4) @(negedge clk);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL illcom_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL illcom_frame%0d: got %p, expected %p", i, obs_q[i], exp_q[i]); end
        end
        n_vec++; if ({bus.dig_a, bus.dig_b, bus.dig_c, bus.err} !== {4'd5, 4'd6, 4'd0, 1'b1}) begin
            n_err++; $display("FAIL illcom_out: got %h/%h/%h err=%b, expected 5/6/0 err=1", bus.dig_a, bus.dig_b, bus.dig_c, bus.err);
        end
    endtask

    task automatic test_back_to_back();
        start_test();
        for (int f = 0; f < 6; f++) begin
            drive_frame($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9), S + 2);
        end
        repeat (S + 6) @(negedge clk);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_frame%0d: got %p, expected %p", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [6:0] pat;
        logic [6:0] alt;
        int         glen;
        start_test();
        for (int f = 0; f < 30; f++) begin
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(0, 9) != 0) begin
                    pat = ($urandom_range(0, 7) == 0) ? 7'($urandom) : SEG_TAB[$urandom_range(0, 9)];
                    drive_slot(COMS[d], pat, $urandom_range(S + 2, S + 6));
                    if ($urandom_range(0, 3) == 0) begin
                        alt  = pat ^ 7'(1 << $urandom_range(0, 6));
                        glen = ($urandom_range(0, 1) == 0) ? $urandom_range(1, S - 2) : $urandom_range(S + 2, S + 4);
                        drive_slot(COMS[d], alt, glen);
                        drive_slot(COMS[d], pat, $urandom_range(S + 2, S + 5));
                    end
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                drive_slot(ILL[$urandom_range(0, 3)], 7'($urandom), S + 3);
            end
            drive_slot(BLANK, 7'h00, $urandom_range(S + 2, S + 6));
        end
        repeat (S + 6) @(negedge clk);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL random_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL random_frame%0d: got %p, expected %p", i, obs_q[i], exp_q[i]); end
        end
        n_vec++; if ({bus.dig_a, bus.dig_b, bus.dig_c} !== {m_dig[0], m_dig[1], m_dig[2]}) begin
            n_err++; $display("FAIL random_final: got %h/%h/%h, expected %h/%h/%h", bus.dig_a, bus.dig_b, bus.dig_c, m_dig[0], m_dig[1], m_dig[2]);
        end
    endtask

    task automatic test_reset_mid_frame();
        start_test();
        drive_frame(8, 2, 5, 8);
        drive_slot(COMS[0], SEG_TAB[6], 8);
        drive_slot(COMS[1], SEG_TAB[1], 8);
        rst = 1'b1;
        #1;
        n_vec++; if ({bus.dig_a, bus.dig_b, bus.dig_c, bus.frame_valid, bus.err, bus.lost} !== 15'd0) begin
            n_err++; $display("FAIL midreset_outputs: got %h/%h/%h fv=%b err=%b lost=%b, expected all 0",
                              bus.dig_a, bus.dig_b, bus.dig_c, bus.frame_valid, bus.err, bus.lost);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        start_test();
        drive_slot(COMS[2], SEG_TAB[4], 8);
        drive_slot(BLANK, 7'h00, 8);
        repeat (S + 4) @(negedge clk);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL midreset_frames: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
        n_vec++; if ({bus.dig_a, bus.dig_b, bus.dig_c} !== 12'd0) begin
            n_err++; $display("FAIL midreset_hold: got %h/%h/%h, expected 0/0/0", bus.dig_a, bus.dig_b, bus.dig_c);
        end
    endtask

    task automatic test_timeout();
        bus.com = BLANK;
        bus.seg = 7'h00;
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        start_test();
        repeat (T - 1) @(negedge clk);
        n_vec++; if (bus.lost !== 1'b0) begin n_err++; $display("FAIL timeout_early: got lost=%b at cycle %0d, expected 0", bus.lost, T - 1); end
        @(negedge clk);
        n_vec++; if (bus.lost !== 1'b1) begin n_err++; $display("FAIL timeout_lost: got lost=%b at cycle %0d, expected 1", bus.lost, T); end
        repeat (10) @(negedge clk);
        drive_frame(2, 0, 7, 8);
        repeat (S + 4) @(negedge clk);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL timeout_count: got %0d frames, expected %0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL timeout_frame%0d: got %p, expected %p", i, obs_q[i], exp_q[i]); end
            n_vec++;
            if (lb_q[i] !== 1'b1) begin n_err++; $display("FAIL timeout_lost_before: got %b, expected 1", lb_q[i]); end
        end
    endtask

    initial begin
        bus.com = BLANK;
        bus.seg = 7'h00;
        test_reset();
        test_basic_frame();
        test_glitch();
        test_invalid_pattern();
        test_missing_digit();
        test_illegal_com();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_display_rx.md
# mux_display_rx

Receiver for the three-digit multiplexed seven-segment display bus. It samples the SEG and COM lines driven by the display scanner and debounces each digit slot. Each stable segment pattern is decoded back to BCD, and a complete A/B/C frame is published at each blank slot. It sits on the bench/loopback side of the display path and lets a board or testbench check displayed values without observing the LEDs.

## Interface
- STABLE_CYC, 4: consecutive identical synchronized samples required before a slot (digit or blank) is accepted; legal range 2..15.
- TIMEOUT, 65535: cycles without a FRAME_VALID before LOST asserts; 16-bit counter.
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- SEG  in  7  segment lines [a:g], SEG[6]=a … SEG[0]=g, active-high; asynchronous to CLK.
- COM  in  3  digit commons, active-low one-hot:
  - COM=3'b011 selects digit A.
  - COM=3'b101 selects digit B.
  - COM=3'b110 selects digit C.
  - COM=3'b111 is the blank slot.
  - Any other value is illegal.
- DIG_A, DIG_B, DIG_C  out  4 each  last published BCD digits.
- FRAME_VALID  out  1  one-cycle pulse; DIG_* updated in the same cycle.
- ERR  out  1  qualified by FRAME_VALID; published frame contained an invalid pattern or an illegal COM.
- LOST  out  1  level; no frame for TIMEOUT cycles.

## Operation
- SEG and COM each pass through a 2-flop synchronizer before any use.
- Stability counter: clears whenever the synchronized {COM,SEG} differs from the previous cycle, increments otherwise, and saturates. A slot is accepted on the cycle the count reaches STABLE_CYC-1. It is accepted at most once per uninterrupted visit.
- Slot FSM states:
  - IDLE → SETTLE on any {COM,SEG} change.
  - SETTLE → ACCEPT when the count is reached.
  - SETTLE → SETTLE (count cleared) on a change.
  - ACCEPT → SETTLE on a change, and otherwise holds.
- Accepted digit slot:
  - SEG is decoded to BCD: 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9.
  - The value is written to the shadow register for that digit and its bit is set in a 3-bit captured mask.
  - Any other SEG pattern writes 4'hF to the shadow register and sets the sticky frame-error bit.
- Accepted illegal COM: sets the sticky frame-error bit; no shadow write.
- Same digit accepted twice before a blank: the later value overwrites the earlier one.
- Accepted blank slot:
  - Mask = 3'b111: shadows copy to DIG_*, FRAME_VALID=1, ERR=sticky error.
  - Any other mask: nothing is published.
  - In both cases the mask and the sticky error bit clear in the same cycle.
- SEG content during the blank slot is ignored.
- Timeout counter:
  - Clears on FRAME_VALID and increments otherwise, saturating at TIMEOUT.
  - LOST=1 while the counter equals TIMEOUT; it clears in the cycle FRAME_VALID asserts.

## Timing
- Reset values:
  - DIG_A/B/C=0, FRAME_VALID=0, ERR=0, LOST=0.
  - Shadows=0, mask=0, counters=0, FSM=IDLE, synchronizers=0.
- Latency from a pin change to slot acceptance: 2 (sync) + STABLE_CYC cycles.
- FRAME_VALID rises 1 cycle after blank acceptance (registered), i.e. 3+STABLE_CYC cycles after COM goes 111 at the pins.
- Glitches shorter than STABLE_CYC cycles are never accepted.
- Reset asserted mid-frame discards all partial capture. The first frame after reset requires a full A, B, C then blank sequence.
- Outputs are registered; no combinational path from pins to outputs.

## Structure
- Shared package: the 7-bit segment constants for digits 0–9, the COM slot encodings (A, B, C, blank), and the invalid-digit code 4'hF. The existing BCD-to-seven-segment encoder and this block share these constants.
- One sub-module, seg7_bcd_decode: combinational 7-bit pattern to {valid, bcd[3:0]}.
- Top block contains the synchronizers, stability counter, slot FSM, shadow/mask registers and timeout counter.

## Test plan
- Scan A=3 (79), B=7 (70), C=9 (7B), each slot held 8 cycles with STABLE_CYC=4, then blank → FRAME_VALID once with DIG_A/B/C=3/7/9, ERR=0.
- Same scan with a 2-cycle SEG glitch to 7F inside slot B → glitch rejected; frame publishes 3/7/9.
- Slot C carries pattern 0x01 → FRAME_VALID with DIG_C=4'hF, ERR=1; the next clean frame has ERR=0.
- Sequence A, B, blank (C missing) → no FRAME_VALID and DIG_* unchanged; the following full frame publishes normally.
- COM=3'b001 held 8 cycles inside a frame → that frame publishes with ERR=1.
- No scanning for TIMEOUT=100 cycles → LOST=1 at cycle 100; a subsequent valid frame clears LOST in the FRAME_VALID cycle.
- RST pulsed after A and B are captured → all outputs 0; then C and blank alone → no FRAME_VALID.
